// File: rtl/hsi_rx_word_fifo_if.sv
// Handshake bundle between the HSI tokenizer / AXI register slice and the
// receive word FIFO. The master side drives the strobes and reads status;
// the slave side is the FIFO itself.
interface hsi_rx_word_fifo_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic              flush;
    logic              clr_ovf;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   level;
    logic              empty;
    logic              full;
    logic              irq_level;
    logic              overflow;

    modport master (
        output valid_in, data_in, rd_en, flush, clr_ovf,
        input  rd_data, rd_valid, level, empty, full, irq_level, overflow
    );

    modport slave (
        input  valid_in, data_in, rd_en, flush, clr_ovf,
        output rd_data, rd_valid, level, empty, full, irq_level, overflow
    );
endinterface

// File: rtl/hsi_rx_word_fifo.sv
// Receive-side word FIFO behind the HSI tokenizer. One word is captured per
// rising edge of the tokenizer strobe, buffered in a DEPTH-entry memory and
// popped with one cycle of read latency. Level, threshold interrupt and a
// sticky overflow flag are provided as registered status.
module hsi_rx_word_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int THRESH = 8
) (
    input logic              clock,
    input logic              reset_n,
    hsi_rx_word_fifo_if.slave bus
);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   THRESH_L = (ADDR_W+1)'(THRESH);
    localparam logic [ADDR_W:0]   LVL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level_r;
    logic [ADDR_W:0]   level_nxt;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic              irq_r;
    logic              ovf_r;
    logic              valid_d;

    logic empty_w;
    logic full_w;
    logic push_evt;
    logic pop_ok;
    logic push_ok;
    logic drop;

    assign empty_w  = (level_r == '0);
    assign full_w   = (level_r == DEPTH_L);

    // A held strobe counts once; flush swallows both push and pop in its cycle.
    assign push_evt = bus.valid_in & ~valid_d;
    assign pop_ok   = bus.rd_en & ~empty_w & ~bus.flush;
    assign push_ok  = push_evt & (~full_w | pop_ok) & ~bus.flush;
    assign drop     = push_evt & full_w & ~pop_ok & ~bus.flush;

    // Next fill level; also feeds the registered threshold flag.
    always_comb begin
        level_nxt = level_r;
        if (bus.flush) begin
            level_nxt = '0;
        end else if (push_ok && !pop_ok) begin
            level_nxt = level_r + LVL_ONE;
        end else if (pop_ok && !push_ok) begin
            level_nxt = level_r - LVL_ONE;
        end
    end

    // Strobe history for rising-edge push detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) valid_d <= 1'b0;
        else          valid_d <= bus.valid_in;
    end

    // Storage array; contents are don't-care after reset or flush.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= bus.data_in;
    end

    // Pointers, level and threshold flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_r <= '0;
            irq_r   <= 1'b0;
        end else begin
            level_r <= level_nxt;
            irq_r   <= (level_nxt >= THRESH_L);
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Read port: rd_data holds its last value unless a pop happens.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= pop_ok;
            if (pop_ok) rd_data_r <= mem[rd_ptr];
        end
    end

    // Sticky overflow; a new drop wins over a simultaneous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)         ovf_r <= 1'b0;
        else if (drop)        ovf_r <= 1'b1;
        else if (bus.clr_ovf) ovf_r <= 1'b0;
    end

    assign bus.rd_data   = rd_data_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.level     = level_r;
    assign bus.empty     = empty_w;
    assign bus.full      = full_w;
    assign bus.irq_level = irq_r;
    assign bus.overflow  = ovf_r;
endmodule

// File: tb/tb_hsi_rx_word_fifo.sv
// Testbench for hsi_rx_word_fifo: directed table, hand-written corner
// sequences and a randomized run, all compared against a queue model.
module tb_hsi_rx_word_fifo;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int THRESH = 8;

    logic clock;
    logic reset_n;

    hsi_rx_word_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    hsi_rx_word_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .THRESH(THRESH)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: word queue plus a few observable bits.
    logic [DATA_W-1:0] m_q [$];
    logic              m_prev;
    logic [DATA_W-1:0] m_rd;
    logic              m_rv;
    logic              m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_prev = 1'b0;
        m_rd   = '0;
        m_rv   = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [DATA_W-1:0] d,
                              input logic r, input logic f, input logic c);
        logic evt;
        logic dropped;
        evt     = v && !m_prev;
        m_prev  = v;
        m_rv    = 1'b0;
        dropped = 1'b0;
        if (f) begin
            m_q.delete();
        end else begin
            if (r && m_q.size() > 0) begin
                m_rd = m_q.pop_front();
                m_rv = 1'b1;
            end
            if (evt) begin
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else dropped = 1'b1;
            end
        end
        if (dropped) m_ovf = 1'b1;
        else if (c)  m_ovf = 1'b0;
    endtask

    task automatic check_model();
        check("level", 32'(bus.level), 32'(m_q.size()));
        check("empty", 32'(bus.empty), 32'(m_q.size() == 0));
        check("full", 32'(bus.full), 32'(m_q.size() == DEPTH));
        check("irq_level", 32'(bus.irq_level), 32'(m_q.size() >= THRESH));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
        check("rd_data", bus.rd_data, m_rd);
    endtask

    // One clock: drive inputs, advance model, sample 1 ns after the edge.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d,
                         input logic r, input logic f, input logic c);
        bus.valid_in = v;
        bus.data_in  = d;
        bus.rd_en    = r;
        bus.flush    = f;
        bus.clr_ovf  = c;
        model_step(v, d, r, f, c);
        @(posedge clock);
        #1;
        check_model();
    endtask

    task automatic strobe(input logic [DATA_W-1:0] d);
        cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] d;
        logic              r;
        logic [ADDR_W:0]   lvl;
        logic              rv;
        logic [DATA_W-1:0] rdd;
    } vec_t;

    vec_t tbl [8];

    initial begin
        // Directed vectors: held strobe, pop, pop on empty, no fall-through.
        tbl[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 5'd1, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 32'hA5A5_0001, 1'b0, 5'd1, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 32'hA5A5_0001, 1'b0, 5'd1, 1'b0, 32'h0};
        tbl[3] = '{1'b0, 32'h0,         1'b1, 5'd0, 1'b1, 32'hA5A5_0001};
        tbl[4] = '{1'b0, 32'h0,         1'b1, 5'd0, 1'b0, 32'hA5A5_0001};
        tbl[5] = '{1'b1, 32'h0000_000B, 1'b1, 5'd1, 1'b0, 32'hA5A5_0001};
        tbl[6] = '{1'b0, 32'h0,         1'b1, 5'd0, 1'b1, 32'h0000_000B};
        tbl[7] = '{1'b0, 32'h0,         1'b0, 5'd0, 1'b0, 32'h0000_000B};

        reset_n      = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.rd_en    = 1'b0;
        bus.flush    = 1'b0;
        bus.clr_ovf  = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_model();
        check("reset_empty", 32'(bus.empty), 32'd1);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_model();

        // Test 1 via table.
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0, 1'b0);
            check($sformatf("tbl%0d_level", i), 32'(bus.level), 32'(tbl[i].lvl));
            check($sformatf("tbl%0d_rv", i), 32'(bus.rd_valid), 32'(tbl[i].rv));
            check($sformatf("tbl%0d_rdd", i), bus.rd_data, tbl[i].rdd);
            check($sformatf("tbl%0d_empty", i), 32'(bus.empty), 32'(tbl[i].lvl == 0));
        end

        // Test 2: fill, irq threshold, overflow drop, ordered drain.
        for (int i = 0; i < DEPTH; i++) begin
            strobe(32'(i));
            check("fill_irq", 32'(bus.irq_level), 32'(i + 1 >= THRESH));
        end
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_ovf_clear", 32'(bus.overflow), 32'd0);
        strobe(32'hDEAD);
        check("drop_ovf", 32'(bus.overflow), 32'd1);
        check("drop_level", 32'(bus.level), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            check("drain_order", bus.rd_data, 32'(i));
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("clr_ovf", 32'(bus.overflow), 32'd0);

        // Test 3: push and pop together while full.
        for (int i = 0; i < DEPTH; i++) strobe(32'(100 + i));
        cycle(1'b1, 32'h1234, 1'b1, 1'b0, 1'b0);
        check("fullpp_level", 32'(bus.level), 32'(DEPTH));
        check("fullpp_ovf", 32'(bus.overflow), 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("fullpp_last", bus.rd_data, 32'h1234);
        check("fullpp_empty", 32'(bus.empty), 32'd1);

        // Test 4: interleaved traffic at level 3 for pointer wrap.
        for (int i = 0; i < 3; i++) strobe(32'h5000 + 32'(i));
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 32'h6000 + 32'(i), 1'b1, 1'b0, 1'b0);
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        end
        check("wrap_level", 32'(bus.level), 32'd3);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("rd_empty_no_valid", 32'(bus.rd_valid), 32'd0);

        // Test 5: flush with simultaneous strobe and pop; then clear vs drop.
        strobe(32'h1);
        for (int i = 0; i < DEPTH + 1; i++) strobe(32'h7000 + 32'(i));
        for (int i = 0; i < DEPTH - 5; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("pre_flush_level", 32'(bus.level), 32'd5);
        check("pre_flush_ovf", 32'(bus.overflow), 32'd1);
        cycle(1'b1, 32'hF1F1, 1'b1, 1'b1, 1'b0);
        check("flush_level", 32'(bus.level), 32'd0);
        check("flush_rv", 32'(bus.rd_valid), 32'd0);
        check("flush_ovf", 32'(bus.overflow), 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("post_flush_rv", 32'(bus.rd_valid), 32'd0);
        for (int i = 0; i < DEPTH; i++) strobe(32'h8000 + 32'(i));
        cycle(1'b1, 32'hEEEE, 1'b0, 1'b0, 1'b1);
        check("clr_vs_drop", 32'(bus.overflow), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("clr_after", 32'(bus.overflow), 32'd0);

        // Test 6: asynchronous reset mid-stream at level 7.
        for (int i = 0; i < 7; i++) strobe(32'h9000 + 32'(i));
        check("pre_reset_level", 32'(bus.level), 32'd7);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_model();
        check("areset_empty", 32'(bus.empty), 32'd1);
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        strobe(32'h0077);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("after_reset_word", bus.rd_data, 32'h0077);

        // Randomized traffic, light then heavy draining.
        for (int i = 0; i < 600; i++) begin
            logic v, r, f, c;
            v = 1'($urandom_range(0, 1));
            r = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 19) == 0);
            cycle(v, $urandom, r, f, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
